// File: rtl/seq_dtree_engine_if.sv
// Handshake and config bundle for the sequential decision-tree engine.
// The master side is the front end / host; the slave side is the engine.
interface seq_dtree_engine_if #(
    parameter int N_FEAT  = 5,
    parameter int FEAT_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int NODE_W  = 16,
    parameter int CLASS_W = 6
);
    logic                      cfg_we;
    logic [ADDR_W-1:0]         cfg_addr;
    logic [NODE_W-1:0]         cfg_wdata;
    logic                      cfg_err;
    logic                      in_valid;
    logic                      in_ready;
    logic [N_FEAT*FEAT_W-1:0]  in_feat;
    logic                      out_valid;
    logic                      out_ready;
    logic [CLASS_W-1:0]        out_class;
    logic [ADDR_W:0]           out_steps;
    logic                      out_err;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
        input  cfg_err, in_ready, out_valid, out_class, out_steps, out_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
        output cfg_err, in_ready, out_valid, out_class, out_steps, out_err
    );
endinterface

// File: rtl/seq_dtree_engine.sv
// Programmable decision-tree classifier: walks a register-based node table
// one node per clock, from root node 0 to a leaf, a bad feature select or a loop timeout.
//
// state | meaning
// IDLE  | ready for a feature vector; config writes accepted
// WALK  | evaluating node[ptr] each cycle
// DONE  | result presented, held until out_ready
module seq_dtree_engine #(
    parameter int N_FEAT    = 5,
    parameter int FEAT_W    = 8,
    parameter int CMP_W     = 4,
    parameter int N_NODES   = 16,
    parameter int FSEL_W    = 3,
    parameter int CLASS_W   = 6,
    parameter int MAX_STEPS = N_NODES
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_dtree_engine_if.slave   bus
);
    localparam int ADDR_W = $clog2(N_NODES);
    localparam int NODE_W = 1 + FSEL_W + CMP_W + 2*ADDR_W;

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t                    state, state_nxt;
    logic [NODE_W-1:0]         node_tbl [N_NODES];
    logic [N_FEAT*FEAT_W-1:0]  feat_q;
    logic [ADDR_W-1:0]         ptr;
    logic [ADDR_W:0]           steps;
    logic [CLASS_W-1:0]        class_q;
    logic [ADDR_W:0]           steps_q;
    logic                      err_q;
    logic                      cfg_err_q;

    logic [NODE_W-1:0]         node;
    logic                      node_leaf;
    logic [FSEL_W-1:0]         node_fsel;
    logic [CMP_W-1:0]          node_thr;
    logic [ADDR_W-1:0]         node_lo;
    logic [ADDR_W-1:0]         node_hi;
    logic [FEAT_W-1:0]         sel_feat;
    logic                      fsel_bad;
    logic                      timeout;
    logic                      go_lo;
    logic                      addr_ok;

    assign node      = node_tbl[ptr];
    assign node_leaf = node[NODE_W-1];
    assign node_fsel = node[NODE_W-2 -: FSEL_W];
    assign node_thr  = node[2*ADDR_W +: CMP_W];
    assign node_lo   = node[ADDR_W +: ADDR_W];
    assign node_hi   = node[0 +: ADDR_W];
    assign fsel_bad  = (int'(node_fsel) >= N_FEAT);
    assign timeout   = (steps == (ADDR_W+1)'(MAX_STEPS));
    assign addr_ok   = (int'(bus.cfg_addr) < N_NODES);

    always_comb begin
        sel_feat = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (node_fsel == FSEL_W'(i)) sel_feat = feat_q[i*FEAT_W +: FEAT_W];
        end
    end

    // MSBs(f) <= thr is the same as f <= {thr, all ones}; avoids slicing off unused LSBs.
    assign go_lo = (sel_feat <= {node_thr, {(FEAT_W-CMP_W){1'b1}}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = WALK;
            WALK:    if (node_leaf || fsel_bad || timeout) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.out_class = class_q;
        bus.out_steps = steps_q;
        bus.out_err   = err_q;
        bus.cfg_err   = cfg_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NODES; i++) node_tbl[i] <= '0;
            feat_q    <= '0;
            ptr       <= '0;
            steps     <= '0;
            class_q   <= '0;
            steps_q   <= '0;
            err_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            if (bus.cfg_we) begin
                if (state == IDLE && addr_ok) node_tbl[bus.cfg_addr] <= bus.cfg_wdata;
                else                          cfg_err_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        feat_q <= bus.in_feat;
                        ptr    <= '0;
                        steps  <= '0;
                    end
                end
                WALK: begin
                    if (node_leaf) begin
                        class_q <= node[CLASS_W-1:0];
                        err_q   <= 1'b0;
                        steps_q <= steps;
                    end else if (fsel_bad || timeout) begin
                        class_q <= '0;
                        err_q   <= 1'b1;
                        steps_q <= steps;
                    end else begin
                        ptr   <= go_lo ? node_lo : node_hi;
                        steps <= steps + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_dtree_engine.sv
// Self-checking bench for seq_dtree_engine: constant vector table, hand-written
// corner sequences and random tables checked against a table-walking reference model.
module tb_seq_dtree_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_dtree_engine_if bus ();
    seq_dtree_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [15:0] mtbl [16];

    typedef struct {
        logic [7:0] f4;
        int cls;
        int stp;
        int err;
        int lat;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: follow the node table by the classifier rules with plain integers.
    function automatic void model(input logic [39:0] f, output int cls, output int stp,
                                  output int err);
        int p;
        logic [15:0] nd;
        logic [7:0] fv;
        int fs;
        p = 0; stp = 0; cls = 0; err = 0;
        for (int k = 0; k < 40; k++) begin
            nd = mtbl[p];
            fs = int'(nd[14:12]);
            if (nd[15]) begin cls = int'(nd[5:0]); return; end
            if (fs >= 5 || stp == 16) begin err = 1; return; end
            fv = 8'((f >> (fs * 8)) & 40'hFF);
            p = (int'(fv) / 16 <= int'(nd[11:8])) ? int'(nd[7:4]) : int'(nd[3:0]);
            stp++;
        end
    endfunction

    task automatic cfg_write(input int a, input logic [15:0] d);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'(a); bus.cfg_wdata = d;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        mtbl[a] = d;
    endtask

    task automatic program_spec_table();
        cfg_write(0, 16'h4712);
        cfg_write(1, 16'h8003);
        cfg_write(2, 16'h802C);
    endtask

    // One inference. Optional config write in the accept cycle; optional DONE hold
    // of 'hold' cycles, with a rejected config write inside the hold if cfg_in_hold.
    task automatic infer(input logic [39:0] f, input int hold, input bit cfg_in_hold,
                         input bit cfg_at_accept, input int ca, input logic [15:0] cd,
                         output int lat, output int cls, output int stp, output int err);
        @(negedge clk);
        chk("in_ready_idle", int'(bus.in_ready), 1);
        bus.in_feat = f; bus.in_valid = 1'b1;
        if (cfg_at_accept) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = 4'(ca); bus.cfg_wdata = cd;
            mtbl[ca] = cd;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.cfg_we = 1'b0;
        bus.in_feat = {8'($urandom), $urandom};
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) chk("out_valid_wait", 0, 1);
        cls = int'(bus.out_class); stp = int'(bus.out_steps); err = int'(bus.out_err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (cfg_in_hold && i == 1) begin
                bus.cfg_we = 1'b1; bus.cfg_addr = 4'd1; bus.cfg_wdata = 16'h8009;
            end
            @(posedge clk); #1;
            bus.cfg_we = 1'b0;
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_class", int'(bus.out_class), cls);
            chk("hold_in_ready", int'(bus.in_ready), 0);
            if (cfg_in_hold && i == 1) chk("cfg_err_pulse", int'(bus.cfg_err), 1);
            if (cfg_in_hold && i == 2) chk("cfg_err_clear", int'(bus.cfg_err), 0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("release_valid", int'(bus.out_valid), 0);
    endtask

    task automatic infer_expect(input string tag, input logic [39:0] f, input int ecls,
                                input int estp, input int eerr, input int elat);
        int lat, cls, stp, err;
        infer(f, 0, 1'b0, 1'b0, 0, 16'h0, lat, cls, stp, err);
        chk({tag, "_class"}, cls, ecls);
        chk({tag, "_steps"}, stp, estp);
        chk({tag, "_err"}, err, eerr);
        chk({tag, "_lat"}, lat, elat);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) mtbl[i] = 16'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int lat, cls, stp, err, mcls, mstp, merr;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        bus.in_valid = 1'b0; bus.in_feat = '0; bus.out_ready = 1'b0;

        vecs[0] = '{8'h70, 3, 1, 0, 2};
        vecs[1] = '{8'h80, 44, 1, 0, 2};
        vecs[2] = '{8'h00, 3, 1, 0, 2};
        vecs[3] = '{8'hFF, 44, 1, 0, 2};
        vecs[4] = '{8'h7F, 3, 1, 0, 2};
        vecs[5] = '{8'h8F, 44, 1, 0, 2};

        do_reset();
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_class", int'(bus.out_class), 0);
        chk("rst_out_steps", int'(bus.out_steps), 0);
        chk("rst_out_err", int'(bus.out_err), 0);
        chk("rst_cfg_err", int'(bus.cfg_err), 0);

        // Cleared table: node 0 loops on itself until the step limit.
        infer_expect("unprog", {8'h55, $urandom}, 0, 16, 1, 17);

        program_spec_table();
        foreach (vecs[i])
            infer_expect("vec", {vecs[i].f4, $urandom}, vecs[i].cls, vecs[i].stp,
                         vecs[i].err, vecs[i].lat);

        cfg_write(0, 16'h802B);
        infer_expect("root_leaf", {8'h12, $urandom}, 43, 0, 0, 1);

        cfg_write(0, 16'h7712);
        infer_expect("bad_fsel", {8'h12, $urandom}, 0, 0, 1, 1);

        // Result held in DONE with a rejected write; table must be unchanged afterwards.
        program_spec_table();
        infer({8'h70, $urandom}, 5, 1'b1, 1'b0, 0, 16'h0, lat, cls, stp, err);
        chk("hold_res_class", cls, 3);
        infer_expect("after_rej", {8'h70, $urandom}, 3, 1, 0, 2);

        // Write and accept in the same cycle: the walk sees the new leaf.
        infer({8'h70, $urandom}, 0, 1'b0, 1'b1, 1, 16'h8005, lat, cls, stp, err);
        chk("same_cyc_class", cls, 5);
        chk("same_cyc_lat", lat, 2);

        // Reset in the middle of a walk.
        program_spec_table();
        @(negedge clk);
        bus.in_feat = {8'h70, 32'h0}; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(bus.out_valid), 0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("postrst_no_result", int'(bus.out_valid), 0);
        end
        infer_expect("cleared", {8'h70, $urandom}, 0, 16, 1, 17);
        program_spec_table();
        infer_expect("reprog", {8'h70, $urandom}, 3, 1, 0, 2);

        // Random tables against the reference model.
        for (int t = 0; t < 10; t++) begin
            for (int n = 0; n < 16; n++) begin
                logic [15:0] w;
                w = 16'($urandom);
                w[15] = ($urandom_range(0, 9) < 4);
                if ($urandom_range(0, 9) != 0) w[14:12] = 3'($urandom_range(0, 4));
                cfg_write(n, w);
            end
            for (int k = 0; k < 15; k++) begin
                logic [39:0] f;
                f = {8'($urandom), $urandom};
                model(f, mcls, mstp, merr);
                infer(f, $urandom_range(0, 3), 1'b0, 1'b0, 0, 16'h0, lat, cls, stp, err);
                chk("rnd_class", cls, mcls);
                chk("rnd_steps", stp, mstp);
                chk("rnd_err", err, merr);
                chk("rnd_lat", lat, mstp + 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
